mul_datapath: RTL

MUL_DATAPATH -- requirements
Module: mul_datapath

---
 rtl/mul_datapath.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mul_datapath.sv
// Datapath of a 32x32 unsigned shift-add multiplier driven step by step by an external controller.
// Optional macro PROTO_CHECK_EN builds a sticky control-sequence violation flag on proto_err.
module mul_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] multiplicand_in,
  input  logic [31:0] multiplier_in,
  input  logic        w_ctrl_Multiplicand,
  input  logic        adding_ctrl,
  input  logic [5:0]  addu_ctrl,
  input  logic        w_ctrl_Product,
  output logic        lsb,
  output logic [63:0] product,
  output logic        product_valid,
  output logic        proto_err
);

  localparam logic [5:0] OP_ADDU   = 6'b100001;
  localparam logic [5:0] SHIFT_MAX = 6'd32;

  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d;
  logic [32:0] alu_q, alu_d;
  logic        pend_q, pend_d;
  logic [5:0]  shift_cnt_q, shift_cnt_d;
  logic        loaded_q, loaded_d;
  logic        valid_q, valid_d;

  logic [32:0] upper_ext;
  logic [32:0] alu_sum;
  logic [32:0] shift_src;
  logic        at_end;
  logic        do_load;
  logic        do_shift;

  // The ALU works on the upper product half widened to 33 bits so the carry of
  // the addition survives into the shift.
  always_comb begin
    upper_ext = {1'b0, prod_q[63:32]};
    if (addu_ctrl == OP_ADDU) begin
      alu_sum = upper_ext + {1'b0, mcand_q};
    end else begin
      alu_sum = upper_ext;
    end
  end

  always_comb begin
    if (adding_ctrl) begin
      shift_src = alu_sum;
    end else if (pend_q) begin
      shift_src = alu_q;
    end else begin
      shift_src = upper_ext;
    end
  end

  assign at_end   = (shift_cnt_q == SHIFT_MAX);
  assign do_load  = w_ctrl_Multiplicand;
  // Shifts are refused until a load has primed the operands.
  assign do_shift = !do_load && w_ctrl_Product && loaded_q && !at_end;

  always_comb begin
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    alu_d       = alu_q;
    pend_d      = pend_q;
    shift_cnt_d = shift_cnt_q;
    loaded_d    = loaded_q;
    valid_d     = valid_q;
    if (do_load) begin
      mcand_d     = multiplicand_in;
      prod_d      = {32'b0, multiplier_in};
      shift_cnt_d = 6'd0;
      pend_d      = 1'b0;
      valid_d     = 1'b0;
      loaded_d    = 1'b1;
    end else begin
      if (adding_ctrl && !w_ctrl_Product) begin
        alu_d  = alu_sum;
        pend_d = 1'b1;
      end
      if (do_shift) begin
        prod_d      = {shift_src, prod_q[31:1]};
        shift_cnt_d = shift_cnt_q + 6'd1;
        pend_d      = 1'b0;
        if (shift_cnt_q == SHIFT_MAX - 6'd1) begin
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q     <= 32'b0;
      prod_q      <= 64'b0;
      alu_q       <= 33'b0;
      pend_q      <= 1'b0;
      shift_cnt_q <= 6'b0;
      loaded_q    <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      alu_q       <= alu_d;
      pend_q      <= pend_d;
      shift_cnt_q <= shift_cnt_d;
      loaded_q    <= loaded_d;
      valid_q     <= valid_d;
    end
  end

  assign lsb           = prod_q[0];
  assign product       = prod_q;
  assign product_valid = valid_q;

`ifdef PROTO_CHECK_EN
  logic proto_err_q, proto_err_d;
  logic violation;

  // A same-cycle load masks the other controls, so it can never be a violation.
  assign violation = !do_load &&
                     ((w_ctrl_Product && loaded_q && at_end) ||
                      ((adding_ctrl || w_ctrl_Product) && !loaded_q));

  always_comb begin
    proto_err_d = proto_err_q;
    if (do_load) begin
      proto_err_d = 1'b0;
    end else if (violation) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule
